// File: rtl/audio_pwm_out.sv
// audio_pwm_out: 1-bit audio modulator (255-cycle PWM or first-order delta-sigma)
// fed through a one-entry pending buffer with overrun detection.
module audio_pwm_out #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    input  logic             ds_mode,
    output logic             pwm_out,
    output logic             load_strobe,
    output logic             overrun
);
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] pend, duty, cnt, acc;
    logic             pend_v, mode_q;
    logic             mode_chg, boundary, load;
    logic [WIDTH:0]   sum;

    assign mode_chg = ds_mode != mode_q;
    assign boundary = mode_q || cnt == CNT_LAST;
    assign load     = boundary && pend_v && !mode_chg;
    assign sum      = {1'b0, acc} + {1'b0, duty};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend        <= '0;
            pend_v      <= 1'b0;
            duty        <= '0;
            cnt         <= '0;
            acc         <= '0;
            mode_q      <= 1'b0;
            pwm_out     <= 1'b0;
            load_strobe <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            mode_q      <= ds_mode;
            load_strobe <= load;
            overrun     <= sample_valid && pend_v && !load;
            pend_v      <= sample_valid || (pend_v && !load);
            if (sample_valid) pend <= sample_in;
            if (load) duty <= pend;
            // a mode switch restarts the modulator from a clean, silent state
            if (mode_chg) begin
                cnt     <= '0;
                acc     <= '0;
                pwm_out <= 1'b0;
            end else if (mode_q) begin
                cnt            <= '0;
                {pwm_out, acc} <= sum;
            end else begin
                cnt     <= boundary ? '0 : cnt + 1'b1;
                pwm_out <= cnt < duty;
            end
        end
    end
endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: directed stimulus with a scoreboard of expected strobes and
// expected pwm_out windows, checked by an independent negedge monitor.
module tb_audio_pwm_out;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic       ds_mode = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       pwm_out, load_strobe, overrun;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    bit flushed = 1'b0;

    typedef struct {
        string name;
        int    cyc;
        bit    ovr;
    } ev_t;
    typedef struct {
        string name;
        int    start;
        int    len;
        int    ones;
        bit    prefix;
    } win_t;

    ev_t  evq[$];
    win_t winq[$];
    int   idx, w_ones, w_bad;

    audio_pwm_out #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .ds_mode(ds_mode),
        .pwm_out(pwm_out),
        .load_strobe(load_strobe),
        .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_ev(input string n, input int c, input bit o);
        evq.push_back('{name: n, cyc: c, ovr: o});
    endfunction

    function automatic void exp_win(input string n, input int s, input int l, input int o, input bit p);
        winq.push_back('{name: n, start: s, len: l, ones: o, prefix: p});
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // PWM frame boundaries sit at edges 258 + 255*m until the first mode change
    task automatic pwm_case(input string n, input int send, input int ld, input logic [7:0] v, input int frames);
        exp_ev(n, ld, 1'b0);
        for (int f = 0; f < frames; f++) exp_win(n, ld + 1 + 255 * f, 255, int'(v), 1'b1);
        wait_cyc(send);
        pulse(v);
    endtask

    always @(negedge clk) begin
        if (!done) begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s strobe missing at cyc=%0d (load/ovr required=%0b/%0b)",
                         evq[0].name, evq[0].cyc, !evq[0].ovr, evq[0].ovr);
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                checks++;
                if (load_strobe !== !evq[0].ovr || overrun !== evq[0].ovr) begin
                    errors++;
                    $display("FAIL %s cyc=%0d load/ovr actual=%b/%b required=%b/%b",
                             evq[0].name, cyc, load_strobe, overrun, !evq[0].ovr, evq[0].ovr);
                end
                void'(evq.pop_front());
            end else if (cyc >= 1 && (load_strobe !== 1'b0 || overrun !== 1'b0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d load/ovr actual=%b/%b required=0/0",
                         cyc, load_strobe, overrun);
            end
            if (winq.size() > 0 && cyc >= winq[0].start) begin
                idx = cyc - winq[0].start;
                if (pwm_out === 1'b1) w_ones++;
                else if (pwm_out !== 1'b0) w_bad++;
                if (winq[0].prefix && ((pwm_out === 1'b1) != (idx < winq[0].ones))) w_bad++;
                if (idx >= winq[0].len - 1) begin
                    checks++;
                    if (w_ones != winq[0].ones || w_bad != 0) begin
                        errors++;
                        $display("FAIL %s window@%0d ones actual=%0d required=%0d misplaced=%0d",
                                 winq[0].name, winq[0].start, w_ones, winq[0].ones, w_bad);
                    end
                    w_ones = 0;
                    w_bad  = 0;
                    void'(winq.pop_front());
                end
            end
        end else if (!flushed) begin
            flushed = 1'b1;
            foreach (evq[i]) begin
                checks++;
                errors++;
                $display("FAIL %s strobe never seen (required at cyc=%0d)", evq[i].name, evq[i].cyc);
            end
            foreach (winq[i]) begin
                checks++;
                errors++;
                $display("FAIL %s window@%0d never completed (required ones=%0d)",
                         winq[i].name, winq[i].start, winq[i].ones);
            end
        end
    end

    initial begin
        exp_win("reset_hold", 1, 3, 0, 1'b0);
        exp_win("idle_after_reset", 4, 600, 0, 1'b0);
        sample_in    = 8'hAA;
        sample_valid = 1'b1;
        wait_cyc(1);
        sample_valid = 1'b0;
        wait_cyc(2);
        sample_valid = 1'b1;
        wait_cyc(3);
        sample_valid = 1'b0;
        rst_n        = 1'b1;

        pwm_case("pwm_40", 610, 768, 8'h40, 2);
        pwm_case("pwm_00", 1033, 1278, 8'h00, 2);
        pwm_case("pwm_ff", 1543, 1788, 8'hFF, 2);
        pwm_case("hold_80", 2053, 2298, 8'h80, 5);

        exp_ev("overrun", 3588, 1'b1);
        wait_cyc(3583);
        pulse(8'h10);
        pwm_case("overrun_20", 3587, 3828, 8'h20, 1);

        exp_ev("same_cycle_old", 4083, 1'b0);
        exp_win("same_cycle_old", 4084, 255, 8'h30, 1'b1);
        wait_cyc(3840);
        pulse(8'h30);
        pwm_case("same_cycle_new", 4082, 4338, 8'h50, 1);

        exp_win("ds_enter", 4601, 2, 0, 1'b0);
        exp_ev("ds_load_40", 4602, 1'b0);
        exp_win("ds_40_a", 4603, 256, 64, 1'b0);
        exp_win("ds_40_b", 4859, 256, 64, 1'b0);
        wait_cyc(4600);
        ds_mode = 1'b1;
        pulse(8'h40);

        exp_ev("ds_load_ff", 5117, 1'b0);
        exp_win("ds_ff", 5118, 256, 255, 1'b0);
        wait_cyc(5115);
        pulse(8'hFF);

        exp_win("ds_exit", 5381, 1, 0, 1'b0);
        exp_win("pwm_after_ds_ff", 5382, 255, 255, 1'b1);
        exp_ev("pwm_after_ds_load", 5636, 1'b0);
        exp_win("pwm_after_ds_20", 5637, 255, 32, 1'b1);
        wait_cyc(5380);
        ds_mode = 1'b0;
        pulse(8'h20);

        exp_win("mid_reset", 5901, 300, 0, 1'b0);
        wait_cyc(5900);
        rst_n = 1'b0;
        pulse(8'h55);
        pulse(8'h66);
        rst_n = 1'b1;

        wait_cyc(6210);
        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
